writeback_regfile: RTL
======================

Name: writeback_regfile

Overview:
- Parametrised next-generation writeback stage: W pipeline register, architectural register file, and retirement/halt tracking in one block.
- Sits after memory_access. Takes M-stage results, commits dstE/dstM writes, and provides decode with register read ports and W-stage forwarding values.
- Adds a sticky halt state machine, dual-write priority rules and a configurable width/register count.

Parameters:
DATA_W, 64, datapath width of valE/valM/register contents
NREG, 15, number of architectural registers (ids 0..NREG-1); id all-ones = RNONE
RID_W, 4, register id width; must satisfy 2**RID_W > NREG
CNT_W, 32, width of retire counter (optional feature)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
stall_i  in  1  hold W register, suppress commit
bubble_i  in  1  load bubble into W register
m_icode_i  in  4  icode from M stage
m_stat_i  in  3  status from M stage
m_valE_i  in  DATA_W  ALU result
m_valM_i  in  DATA_W  memory read result
m_dstE_i  in  RID_W  destination for valE
m_dstM_i  in  RID_W  destination for valM
d_srcA_i  in  RID_W  read port A address
d_srcB_i  in  RID_W  read port B address
d_rvalA_o  out  DATA_W  register file contents at srcA (0 if RNONE)
d_rvalB_o  out  DATA_W  register file contents at srcB (0 if RNONE)
W_icode_o  out  4  W register icode
W_stat_o  out  3  W register status
W_valE_o  out  DATA_W  W register valE (forwarding)
W_valM_o  out  DATA_W  W register valM (forwarding)
W_dstE_o  out  RID_W  W register dstE
W_dstM_o  out  RID_W  W register dstM
halted_o  out  1  sticky: exceptional status retired
retire_cnt_o  out  CNT_W  retired-instruction count

Behaviour:
- Clock clk_i, reset rst_n_i; reset is asynchronous, active-low, one clock domain.
- Reset values: W_icode=INOP, W_stat=SAOK, W_dstE=W_dstM=RNONE, W_valE=W_valM=0, all registers 0, halted_o=0, retire_cnt_o=0, FSM=RUN.
- W register update, priority stall > bubble > load. stall_i holds the register. bubble_i (without stall_i) loads bubble values, the same as the reset values. Otherwise the register loads the m_* inputs.
- Commit takes place at the edge after the instruction is latched into W, so write latency is 2 edges from m_* valid. Commit condition: FSM==RUN, !stall_i, W_stat==SAOK.
- On commit, regs[W_dstE] <= W_valE when W_dstE != RNONE, and regs[W_dstM] <= W_valM when W_dstM != RNONE.
- If W_dstE==W_dstM (both != RNONE), valM wins (popq %rsp semantics).
- Ids >= NREG other than RNONE are ignored. No write occurs and no error is raised.
- Reads are combinational from the array with no internal bypass. Same-cycle write forwarding belongs to decode via W_* outputs. A read at an edge returns the pre-write value.
- FSM states:
  - RUN -> HALTED when, at an edge with !stall_i, W_stat is in {SHLT, SADR, SINS}. That instruction performs no register write.
  - HALTED is absorbing until reset. No commits occur in HALTED, and the W register still obeys stall/bubble.
  - halted_o = (FSM==HALTED).
- Reset asserted mid-operation: all state clears immediately (async). No partial write survives.

Optional Feature:
- Macro WB_RETIRE_CNT_EN.
- Defined: retire_cnt_o increments by 1 on each commit whose W_icode != INOP. It saturates at all-ones.
- Undefined: retire_cnt_o is tied to 0 and no counter flops are inferred. The port is always present.

Decomposition:
- Shared package/defines: icode constants (INOP, IHALT, IPOPQ...), stat codes (SAOK=1, SHLT=2, SADR=3, SINS=4), RNONE, bubble defaults. All extend define.v.
- One sub-module: regfile_2w2r (NREG x DATA_W, two write ports with port-M priority, two combinational reads).

Test Plan:
1. Reset then read srcA=0, srcB=14 -> d_rvalA_o=d_rvalB_o=0, W_dstE_o=4'hF, halted_o=0.
2. m_dstE=3, valE=0x1234, stat=SAOK, icode=IOPQ; two edges later read srcA=3 -> 0x1234. At the intermediate edge, read -> 0.
3. dstE=dstM=4, valE=8, valM=0x55 -> reg4=0x55.
4. stall_i=1 for 3 cycles with an SAOK write in W -> no write and W_* held. Releasing the stall -> write occurs once, and retire_cnt (if enabled) +1 only.
5. Retire stat=SADR with dstE=2, valE=7 -> reg2 unchanged, halted_o=1. A later SAOK write to reg2 is ignored. Asserting rst_n_i=0 mid-cycle -> halted_o=0 immediately.
6. WB_RETIRE_CNT_EN with CNT_W=4: 20 committed non-NOP instructions -> retire_cnt_o=15. Bubbles do not count.

Source files
------------

// File: rtl/writeback_regfile_pkg.sv
// writeback_regfile_pkg: shared Y86-64 style constants for the writeback stage.
//   - icode constants (INOP, IHALT, IOPQ, IPOPQ, ...)
//   - status codes (SAOK=1, SHLT=2, SADR=3, SINS=4)
//   - W-register bubble defaults and writeback FSM state type
//   - stat_is_exception(): true for status codes that stop retirement
package writeback_regfile_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  // Bubble contents of the W register (identical to its reset contents)
  localparam logic [3:0] BUBBLE_ICODE = INOP;
  localparam logic [2:0] BUBBLE_STAT  = SAOK;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } wb_state_e;

  function automatic logic stat_is_exception(input logic [2:0] stat);
    logic exc;
    case (stat)
      SHLT:    exc = 1'b1;
      SADR:    exc = 1'b1;
      SINS:    exc = 1'b1;
      default: exc = 1'b0;
    endcase
    return exc;
  endfunction

endpackage

// File: rtl/writeback_regfile_rf.sv
// writeback_regfile_rf: NREG x DATA_W architectural register file,
// two write ports (E and M, M wins on a same-id collision) and two
// combinational read ports with no internal bypass.
// Ports:
//   clk, rst_n             clock, async active-low reset (clears all regs)
//   we_e, wid_e, wdata_e   write port E (valE)
//   we_m, wid_m, wdata_m   write port M (valM, priority)
//   rid_a, rid_b           read addresses
//   rdata_a, rdata_b       read data (0 for any id >= NREG, including RNONE)
module writeback_regfile_rf #(
  parameter int DATA_W = 64,
  parameter int NREG   = 15,
  parameter int RID_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_e,
  input  logic [RID_W-1:0]  wid_e,
  input  logic [DATA_W-1:0] wdata_e,
  input  logic              we_m,
  input  logic [RID_W-1:0]  wid_m,
  input  logic [DATA_W-1:0] wdata_m,
  input  logic [RID_W-1:0]  rid_a,
  input  logic [RID_W-1:0]  rid_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs_r [NREG];

  // Register array: ids that match no entry (>= NREG) simply write nothing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (we_m && (wid_m == i[RID_W-1:0])) begin
          regs_r[i] <= wdata_m;
        end else if (we_e && (wid_e == i[RID_W-1:0])) begin
          regs_r[i] <= wdata_e;
        end else begin
          regs_r[i] <= regs_r[i];
        end
      end
    end
  end

  // Read mux: searching the entries keeps out-of-range ids at zero
  always_comb begin
    rdata_a = {DATA_W{1'b0}};
    rdata_b = {DATA_W{1'b0}};
    for (int i = 0; i < NREG; i++) begin
      if (rid_a == i[RID_W-1:0]) begin
        rdata_a = regs_r[i];
      end else begin
        rdata_a = rdata_a;
      end
      if (rid_b == i[RID_W-1:0]) begin
        rdata_b = regs_r[i];
      end else begin
        rdata_b = rdata_b;
      end
    end
  end

endmodule

// File: rtl/writeback_regfile.sv
// writeback_regfile: W pipeline register, architectural register file and
// sticky halt tracking for the writeback stage.
// Ports:
//   clk_i, rst_n_i        clock, async active-low reset
//   stall_i, bubble_i     W register control (stall > bubble > load)
//   m_*_i                 M-stage results loaded into W
//   d_srcA_i/d_srcB_i     decode read addresses, d_rvalA_o/d_rvalB_o data
//   W_*_o                 W register contents (forwarding to decode)
//   halted_o              sticky, set when an exceptional status retires
//   retire_cnt_o          saturating count of retired non-NOP instructions
// Optional feature: define WB_RETIRE_CNT_EN to build the retire counter;
// without it retire_cnt_o is constant zero.
module writeback_regfile
  import writeback_regfile_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int NREG   = 15,
  parameter int RID_W  = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              stall_i,
  input  logic              bubble_i,
  input  logic [3:0]        m_icode_i,
  input  logic [2:0]        m_stat_i,
  input  logic [DATA_W-1:0] m_valE_i,
  input  logic [DATA_W-1:0] m_valM_i,
  input  logic [RID_W-1:0]  m_dstE_i,
  input  logic [RID_W-1:0]  m_dstM_i,
  input  logic [RID_W-1:0]  d_srcA_i,
  input  logic [RID_W-1:0]  d_srcB_i,
  output logic [DATA_W-1:0] d_rvalA_o,
  output logic [DATA_W-1:0] d_rvalB_o,
  output logic [3:0]        W_icode_o,
  output logic [2:0]        W_stat_o,
  output logic [DATA_W-1:0] W_valE_o,
  output logic [DATA_W-1:0] W_valM_o,
  output logic [RID_W-1:0]  W_dstE_o,
  output logic [RID_W-1:0]  W_dstM_o,
  output logic              halted_o,
  output logic [CNT_W-1:0]  retire_cnt_o
);

  localparam logic [RID_W-1:0] RNONE = {RID_W{1'b1}};

  logic [3:0]        w_icode_r;
  logic [2:0]        w_stat_r;
  logic [DATA_W-1:0] w_vale_r;
  logic [DATA_W-1:0] w_valm_r;
  logic [RID_W-1:0]  w_dste_r;
  logic [RID_W-1:0]  w_dstm_r;
  wb_state_e         state_r;

  logic commit_s;
  logic we_e_s;
  logic we_m_s;

  // W pipeline register: stall holds, bubble injects a NOP, otherwise load M
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      w_icode_r <= BUBBLE_ICODE;
      w_stat_r  <= BUBBLE_STAT;
      w_vale_r  <= {DATA_W{1'b0}};
      w_valm_r  <= {DATA_W{1'b0}};
      w_dste_r  <= RNONE;
      w_dstm_r  <= RNONE;
    end else if (stall_i) begin
      w_icode_r <= w_icode_r;
      w_stat_r  <= w_stat_r;
      w_vale_r  <= w_vale_r;
      w_valm_r  <= w_valm_r;
      w_dste_r  <= w_dste_r;
      w_dstm_r  <= w_dstm_r;
    end else if (bubble_i) begin
      w_icode_r <= BUBBLE_ICODE;
      w_stat_r  <= BUBBLE_STAT;
      w_vale_r  <= {DATA_W{1'b0}};
      w_valm_r  <= {DATA_W{1'b0}};
      w_dste_r  <= RNONE;
      w_dstm_r  <= RNONE;
    end else begin
      w_icode_r <= m_icode_i;
      w_stat_r  <= m_stat_i;
      w_vale_r  <= m_valE_i;
      w_valm_r  <= m_valM_i;
      w_dste_r  <= m_dstE_i;
      w_dstm_r  <= m_dstM_i;
    end
  end

  // Halt FSM: an exceptional status leaving W (not stalled) stops all commits
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= ST_RUN;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (!stall_i && stat_is_exception(w_stat_r)) begin
            state_r <= ST_HALTED;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_HALTED: state_r <= ST_HALTED;
        default:   state_r <= ST_HALTED;
      endcase
    end
  end

  // An exceptional instruction fails the SAOK test, so it never writes
  assign commit_s = (state_r == ST_RUN) && !stall_i && (w_stat_r == SAOK);
  assign we_e_s   = commit_s && (w_dste_r != RNONE);
  assign we_m_s   = commit_s && (w_dstm_r != RNONE);

  writeback_regfile_rf #(
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .RID_W  (RID_W)
  ) u_rf (
    .clk     (clk_i),
    .rst_n   (rst_n_i),
    .we_e    (we_e_s),
    .wid_e   (w_dste_r),
    .wdata_e (w_vale_r),
    .we_m    (we_m_s),
    .wid_m   (w_dstm_r),
    .wdata_m (w_valm_r),
    .rid_a   (d_srcA_i),
    .rid_b   (d_srcB_i),
    .rdata_a (d_rvalA_o),
    .rdata_b (d_rvalB_o)
  );

  assign W_icode_o = w_icode_r;
  assign W_stat_o  = w_stat_r;
  assign W_valE_o  = w_vale_r;
  assign W_valM_o  = w_valm_r;
  assign W_dstE_o  = w_dste_r;
  assign W_dstM_o  = w_dstm_r;
  assign halted_o  = (state_r == ST_HALTED);

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] retire_cnt_r;

  // Retire counter: counts committed non-NOP instructions, saturating
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      retire_cnt_r <= {CNT_W{1'b0}};
    end else if (commit_s && (w_icode_r != INOP) && (retire_cnt_r != {CNT_W{1'b1}})) begin
      retire_cnt_r <= retire_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      retire_cnt_r <= retire_cnt_r;
    end
  end

  assign retire_cnt_o = retire_cnt_r;
`else
  assign retire_cnt_o = {CNT_W{1'b0}};
`endif

endmodule
